// File: rtl/aww_types_pkg.sv
// Arbiter-local types: grant state of the memory arbiter.
package aww_types_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    ERR  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake state.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between datapath, arbiter and the single-port RAM.
interface mem_arbiter_if (
  input logic CLK,
  input logic nRST
);
  import cpu_types_pkg::*;

  logic      iREN, dREN, dWEN;
  logic      ihit, dhit, arb_err;
  logic      ramREN, ramWEN;
  word_t     iaddr, iload, daddr, dstore, dload;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport ma (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, dload, ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport dp (
    input  CLK, nRST, iload, dload, ihit, dhit, arb_err,
    output iREN, iaddr, dREN, dWEN, daddr, dstore
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port;
// data wins over fetch, a grant is held until hit, abort, RAM error or timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        ihit,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);
  import cpu_types_pkg::*;
  import aww_types_pkg::*;

  arb_state_t       state_q, state_d, prio;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ramstate_t        rs;
  logic             timeout_c;

  assign rs        = ramstate_t'(ramstate);
  assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT - 1));
  assign arb_err   = (state_q == ERR);

  // Grant choice when idle or finishing: data beats fetch
  always_comb begin
    prio = IDLE;
    if (dREN || dWEN) prio = DACC;
    else if (iREN)    prio = IACC;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes and hits decode from registered state plus the live RAM status
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: state_d = prio;

      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (rs == ERROR) begin
          state_d = ERR;
        end else if (!iREN) begin
          state_d = prio;
        end else if (rs == ACCESS) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = prio;
        end else if (timeout_c) begin
          state_d = ERR;
        end
      end

      DACC: begin
        ramREN   = dREN;
        ramWEN   = dWEN & ~dREN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (rs == ERROR) begin
          state_d = ERR;
        end else if (!(dREN || dWEN)) begin
          state_d = prio;
        end else if (rs == ACCESS) begin
          dhit    = 1'b1;
          dload   = dREN ? ramload : '0;
          state_d = prio;
        end else if (timeout_c) begin
          state_d = ERR;
        end
      end

      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Wait counter restarts with every new grant or completed access
    if ((state_d != state_q) || ihit || dhit) begin
      cnt_d = '0;
    end else if (((state_q == IACC) || (state_q == DACC)) && (cnt_q < CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
endmodule
